// File: rtl/ot_read_stream.sv
// ot_read_stream
//   Streams cfg_length words out of NUM_BANKS word-interleaved output-SRAM
//   banks into a downstream FIFO. Word i is read from bank (i mod NUM_BANKS)
//   at address cfg_base_addr + i/NUM_BANKS (wrapping at 2^ADDR_BITS). Reads
//   are issued against credits, so the skid FIFO always has room for every
//   word still in flight through the SRAM. When the downstream FIFO stalls,
//   no word is lost.
//
// Ports
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   start            1-cycle pulse, ignored while busy
//   cfg_base_addr    per-bank start address, latched on start
//   cfg_length       number of words, latched on start (0 = empty job)
//   busy / done      transfer in progress / 1-cycle completion pulse
//   fifo_full_n      downstream can accept a word this cycle
//   fifo_write       word handed downstream this cycle
//   fifo_last        final word of the job (qualified by fifo_write)
//   fifo_data        word data (0 when nothing is buffered)
//   cen_otsr         per-bank chip enable, active low
//   wen_otsr         per-bank write enable, tied high (read only)
//   addr_otsr        per-bank address, bank b at [b*ADDR_BITS +: ADDR_BITS]
//   data_from_sram   per-bank read data, same packing
module ot_read_stream #(
  parameter int unsigned DATA_BITS  = 64,
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned LEN_BITS   = 16,
  parameter int unsigned SRAM_LAT   = 1,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ADDR_BITS-1:0]           cfg_base_addr,
  input  logic [LEN_BITS-1:0]            cfg_length,
  output logic                           busy,
  output logic                           done,
  input  logic                           fifo_full_n,
  output logic                           fifo_write,
  output logic                           fifo_last,
  output logic [DATA_BITS-1:0]           fifo_data,
  output logic [NUM_BANKS-1:0]           cen_otsr,
  output logic [NUM_BANKS-1:0]           wen_otsr,
  output logic [NUM_BANKS*ADDR_BITS-1:0] addr_otsr,
  input  logic [NUM_BANKS*DATA_BITS-1:0] data_from_sram
);

  localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned BANK_SH = $clog2(NUM_BANKS);
  localparam int unsigned PTR_W   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(SKID_DEPTH + SRAM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   base_q, base_d;
  logic [LEN_BITS-1:0]    len_q, len_d;
  logic [LEN_BITS-1:0]    issued_q, issued_d;
  logic [LEN_BITS-1:0]    popped_q, popped_d;

  // SRAM latency tracker: one valid/bank entry per outstanding read cycle
  logic [SRAM_LAT-1:0]    pipe_vld_q;
  logic [BANK_W-1:0]      pipe_bank_q [SRAM_LAT];

  // Skid FIFO
  logic [DATA_BITS-1:0]   skid_mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       skid_cnt_q, skid_cnt_d;

  logic                   issue;
  logic [BANK_W-1:0]      issue_bank;
  logic [ADDR_BITS-1:0]   issue_addr;
  logic [CNT_W-1:0]       inflight;
  logic                   ret_vld;
  logic [BANK_W-1:0]      ret_bank;
  logic [DATA_BITS-1:0]   ret_data;
  logic                   skid_nonempty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < SRAM_LAT; k++) begin
      inflight = inflight + CNT_W'(pipe_vld_q[k]);
    end
  end

  // Credits: every read not yet handed downstream holds one skid slot, whether
  // it is still inside the SRAM or already buffered. A same-cycle pop does not
  // free a credit, which keeps this path independent of fifo_full_n.
  assign issue = (state_q == S_RUN) && (issued_q < len_q) &&
                 ((inflight + skid_cnt_q) < CNT_W'(SKID_DEPTH));

  assign issue_bank = (NUM_BANKS > 1) ? issued_q[BANK_W-1:0] : '0;
  assign issue_addr = base_q + ADDR_BITS'(issued_q >> BANK_SH);

  always_comb begin
    cen_otsr  = '1;
    addr_otsr = '0;
    if (issue) begin
      cen_otsr[issue_bank]                          = 1'b0;
      addr_otsr[issue_bank*ADDR_BITS +: ADDR_BITS]  = issue_addr;
    end
  end

  assign wen_otsr = '1;

  // ---------------------------------------------------------------------------
  // Return side: the oldest pipe stage marks the cycle its bank's data is valid
  // ---------------------------------------------------------------------------
  assign ret_vld  = pipe_vld_q[SRAM_LAT-1];
  assign ret_bank = pipe_bank_q[SRAM_LAT-1];
  assign ret_data = data_from_sram[ret_bank*DATA_BITS +: DATA_BITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int unsigned k = 0; k < SRAM_LAT; k++) begin
        pipe_bank_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_bank_q[0] <= issue_bank;
      for (int unsigned k = 1; k < SRAM_LAT; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_bank_q[k] <= pipe_bank_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO and downstream interface
  // ---------------------------------------------------------------------------
  assign skid_nonempty = (skid_cnt_q != '0);
  assign fifo_write    = skid_nonempty && fifo_full_n;
  assign fifo_data     = skid_nonempty ? skid_mem_q[rd_ptr_q] : '0;
  assign fifo_last     = fifo_write && (popped_q == len_q - LEN_BITS'(1));

  always_comb begin
    skid_cnt_d = skid_cnt_q;
    case ({ret_vld, fifo_write})
      2'b10:   skid_cnt_d = skid_cnt_q + CNT_W'(1);
      2'b01:   skid_cnt_d = skid_cnt_q - CNT_W'(1);
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skid_cnt_q <= '0;
    end else begin
      if (ret_vld) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (fifo_write) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      skid_cnt_q <= skid_cnt_d;
    end
  end

  // Storage needs no reset: fifo_data is gated by the occupancy count
  always_ff @(posedge clk) begin
    if (ret_vld) begin
      skid_mem_q[wr_ptr_q] <= ret_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q + LEN_BITS'(issue);
    popped_d = popped_q + LEN_BITS'(fifo_write);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = cfg_base_addr;
          len_d    = cfg_length;
          issued_d = '0;
          popped_d = '0;
          state_d  = (cfg_length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issued_q == len_q - LEN_BITS'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_write && fifo_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_ot_read_stream.sv
module tb_ot_read_stream;

  localparam int NB    = 2;
  localparam int AB    = 10;
  localparam int DB    = 64;
  localparam int LB    = 16;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [AB-1:0]    cfg_base_addr;
  logic [LB-1:0]    cfg_length;
  logic             busy, done;
  logic             fifo_full_n;
  logic             fifo_write, fifo_last;
  logic [DB-1:0]    fifo_data;
  logic [NB-1:0]    cen_otsr, wen_otsr;
  logic [NB*AB-1:0] addr_otsr;
  logic [NB*DB-1:0] data_from_sram;

  ot_read_stream #(
    .DATA_BITS (DB),
    .ADDR_BITS (AB),
    .NUM_BANKS (NB),
    .LEN_BITS  (LB),
    .SRAM_LAT  (LAT),
    .SKID_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_length    (cfg_length),
    .busy          (busy),
    .done          (done),
    .fifo_full_n   (fifo_full_n),
    .fifo_write    (fifo_write),
    .fifo_last     (fifo_last),
    .fifo_data     (fifo_data),
    .cen_otsr      (cen_otsr),
    .wen_otsr      (wen_otsr),
    .addr_otsr     (addr_otsr),
    .data_from_sram(data_from_sram)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank contents and a one-cycle-latency SRAM model
  logic [DB-1:0] mem [NB][1 << AB];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      data_from_sram <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (!cen_otsr[b]) data_from_sram[b*DB +: DB] <= mem[b][addr_otsr[b*AB +: AB]];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference job description and progress
  int exp_base, exp_len;
  int iss_idx, wr_idx, done_cnt, t0;
  int first_cen, first_wr, done_rel;

  function automatic logic [63:0] exp_word(input int i);
    return mem[i % NB][(exp_base + i / NB) % (1 << AB)];
  endfunction

  // Monitor: every SRAM read and every downstream word against the job model
  always @(negedge clk) begin
    if (!reset) begin
      int nlow;
      int rel;
      rel  = cyc - t0;
      nlow = 0;
      for (int b = 0; b < NB; b++) if (!cen_otsr[b]) nlow++;
      chk("one_bank_per_cycle", 64'(nlow <= 1), 64'd1);
      for (int b = 0; b < NB; b++) begin
        if (!cen_otsr[b]) begin
          chk("issue_in_range", 64'(iss_idx < exp_len), 64'd1);
          chk("issue_bank", 64'(b), 64'(iss_idx % NB));
          chk("issue_addr", 64'(addr_otsr[b*AB +: AB]), 64'((exp_base + iss_idx / NB) % (1 << AB)));
          if (first_cen < 0) first_cen = rel;
          iss_idx++;
        end
      end
      if (fifo_write) begin
        chk("write_in_range", 64'(wr_idx < exp_len), 64'd1);
        chk("word_data", fifo_data, exp_word(wr_idx));
        chk("word_last", 64'(fifo_last), 64'(wr_idx == exp_len - 1));
        if (first_wr < 0) first_wr = rel;
        wr_idx++;
      end else begin
        chk("last_without_write", 64'(fifo_last), 64'd0);
      end
      chk("credit_bound", 64'((iss_idx - wr_idx) <= DEPTH), 64'd1);
      if (done) begin
        done_cnt++;
        done_rel = rel;
        chk("done_after_all_words", 64'(wr_idx), 64'(exp_len));
      end
    end
  end

  task automatic start_job(input int b, input int l);
    @(posedge clk); #1;
    cfg_base_addr = AB'(b);
    cfg_length    = LB'(l);
    start         = 1'b1;
    exp_base  = b;
    exp_len   = l;
    iss_idx   = 0;
    wr_idx    = 0;
    done_cnt  = 0;
    first_cen = -1;
    first_wr  = -1;
    done_rel  = -1;
    t0        = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until done (bounded), optionally throttling the downstream FIFO
  task automatic wait_done(input int maxc, input bit bp);
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin
      @(posedge clk); #1;
      fifo_full_n = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    fifo_full_n = 1'b1;
    chk("done_within_budget", 64'(done_cnt), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("all_words_delivered", 64'(wr_idx), 64'(exp_len));
    chk("all_reads_issued", 64'(iss_idx), 64'(exp_len));
    chk("done_once", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < (1 << AB); a++)
        mem[b][a] = {$urandom, $urandom};
    reset = 1'b1; start = 1'b0; cfg_base_addr = '0; cfg_length = '0; fifo_full_n = 1'b1;
    exp_base = 0; exp_len = 0; iss_idx = 0; wr_idx = 0; done_cnt = 0; t0 = 0;
    first_cen = -1; first_wr = -1; done_rel = -1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fifo_write", 64'(fifo_write), 64'd0);
    chk("rst_cen", 64'(cen_otsr), 64'(2'b11));
    chk("rst_wen", 64'(wen_otsr), 64'(2'b11));
    chk("rst_addr", 64'(addr_otsr), 64'd0);
    chk("rst_fifo_data", fifo_data, 64'd0);

    // 1: base 0, length 20, no backpressure, latency
    start_job(0, 20);
    wait_done(200, 1'b0);
    chk("t1_first_cen_cycle", 64'(first_cen), 64'd1);
    chk("t1_first_write_cycle", 64'(first_wr), 64'd3);
    chk("t1_done_cycle", 64'(done_rel), 64'd23);

    // 2: random backpressure, random base, length 37
    start_job(int'($urandom_range(0, (1 << AB) - 1)), 37);
    wait_done(2000, 1'b1);

    // 3: address wrap at the top of each bank
    start_job((1 << AB) - 2, 8);
    wait_done(200, 1'b0);

    // 4: empty job, plus a start pulse during its DONE cycle
    start_job(0, 0);
    cfg_length = LB'(5);
    start      = 1'b1;
    @(negedge clk);
    chk("t4_busy_cycle1", 64'(busy), 64'd1);
    chk("t4_done_cycle1", 64'(done), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t4_busy_cycle2", 64'(busy), 64'd0);
    chk("t4_done_cycle2", 64'(done), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_no_reads", 64'(iss_idx), 64'd0);
    chk("t4_no_writes", 64'(wr_idx), 64'd0);
    chk("t4_done_once", 64'(done_cnt), 64'd1);

    // 5: reset mid-transfer, then a fresh job
    start_job(300, 20);
    begin
      int n = 0;
      while (wr_idx < 5 && n < 100) begin @(posedge clk); n++; end
      chk("t5_reached_word5", 64'(wr_idx >= 5), 64'd1);
    end
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_write", 64'(fifo_write), 64'd0);
    chk("t5_rst_cen", 64'(cen_otsr), 64'(2'b11));
    chk("t5_rst_data", fifo_data, 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done_aborted", 64'(done_cnt), 64'd0);
    chk("t5_idle_after_abort", 64'(busy), 64'd0);
    start_job(100, 4);
    wait_done(100, 1'b0);
    chk("t5_first_write_cycle", 64'(first_wr), 64'd3);

    // 6: start with different cfg during RUN is ignored
    start_job(50, 30);
    repeat (4) @(posedge clk);
    #1;
    cfg_base_addr = AB'(7);
    cfg_length    = LB'(3);
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
